// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode encodings and default width for the shared ALU
// Revision: 1.0
// ============================================================================
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : combinational WIDTH-bit ALU, carry = ADD carry-out / SUB borrow
// Revision: 1.0
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // The extra top bit of the zero-extended difference is the unsigned borrow.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD:  begin y = w_sum[WIDTH-1:0];  carry = w_sum[WIDTH];  end
            OP_SUB:  begin y = w_diff[WIDTH-1:0]; carry = w_diff[WIDTH]; end
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// alu_rr_arbiter : two-requester round-robin front end to a shared ALU with a
//                  single registered response slot (valid/ready both sides)
// Revision: 1.0
// ============================================================================
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_carry,
    output logic             rsp_zero
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_last_gnt;
    logic             r_id;
    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic             r_zero;

    logic             w_can_accept;
    logic             w_grant;
    logic             w_accept;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_y;
    logic             w_carry;
    logic             w_zero;

    assign w_can_accept = (r_state == S_EMPTY) | rsp_ready;

    // On contention the requester that did not win last time goes first.
    assign w_grant  = (req0_valid & req1_valid) ? ~r_last_gnt : req1_valid;
    assign w_accept = w_can_accept & (req0_valid | req1_valid) & ~rst;

    assign w_op = w_grant ? req1_op : req0_op;
    assign w_a  = w_grant ? req1_a  : req0_a;
    assign w_b  = w_grant ? req1_b  : req0_b;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op    (w_op),
        .a     (w_a),
        .b     (w_b),
        .y     (w_y),
        .carry (w_carry),
        .zero  (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (rsp_ready && !w_accept) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid  = (r_state == S_FULL);
        req0_ready = w_accept & ~w_grant;
        req1_ready = w_accept & w_grant;
        rsp_id     = r_id;
        rsp_y      = r_y;
        rsp_carry  = r_carry;
        rsp_zero   = r_zero;
    end

    // Response payload and grant history only move on a real accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
            r_id       <= 1'b0;
            r_y        <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_last_gnt <= w_grant;
            r_id       <= w_grant;
            r_y        <= w_y;
            r_carry    <= w_carry;
            r_zero     <= w_zero;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_rr_arbiter : scenario tasks plus a response scoreboard for alu_rr_arbiter
// Revision: 1.0
// ============================================================================
module tb_alu_rr_arbiter;

    localparam int W = 8;

    typedef struct packed {
        logic         id;
        logic [W-1:0] y;
        logic         carry;
        logic         zero;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero;
    logic [W-1:0] rsp_y;

    int   total = 0;
    int   bad   = 0;
    rsp_t sb_q[$];

    always #5 clk = ~clk;

    alu_rr_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero)
    );

    function automatic rsp_t model(input logic id, input logic [2:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        rsp_t    r;
        int      ia, ib, s;
        ia = int'(a);
        ib = int'(b);
        r.id    = id;
        r.carry = 1'b0;
        case (op)
            3'd0: begin s = ia + ib; r.y = W'(s); r.carry = (s >= 256); end
            3'd1: begin s = ia - ib + 256; r.y = W'(s); r.carry = (ia < ib); end
            3'd2: r.y = a & b;
            3'd3: r.y = a ^ b;
            3'd4: r.y = a | b;
            3'd5: r.y = ~(a & b);
            3'd6: r.y = ~(a | b);
            default: r.y = ~(a ^ b);
        endcase
        r.zero = (r.y == '0);
        return r;
    endfunction

    // Scoreboard: drain first (slot content predates this cycle's accept), then enqueue.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got id=%0d y=%02h with nothing expected", rsp_id, rsp_y);
                end else begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    if ({rsp_id, rsp_y, rsp_carry, rsp_zero} !== e) begin
                        bad++;
                        $display("FAIL sb_rsp: got id=%0d y=%02h c=%0d z=%0d want id=%0d y=%02h c=%0d z=%0d",
                                 rsp_id, rsp_y, rsp_carry, rsp_zero, e.id, e.y, e.carry, e.zero);
                    end
                end
            end
            if (req0_ready) sb_q.push_back(model(1'b0, req0_op, req0_a, req0_b));
            if (req1_ready) sb_q.push_back(model(1'b1, req1_op, req1_a, req1_b));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'd1; req0_b = 8'd1;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'd2; req1_b = 8'd2;
        repeat (2) tick();
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_carry, rsp_zero} !== 12'h0) begin
            bad++;
            $display("FAIL reset_rsp: got v=%0d id=%0d y=%02h c=%0d z=%0d want all 0",
                     rsp_valid, rsp_id, rsp_y, rsp_carry, rsp_zero);
        end
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'd200; req0_b = 8'd100;
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL add_ready: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_carry, rsp_zero} !== {1'b1, 1'b0, 8'd44, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL add_rsp: got v=%0d id=%0d y=%0d c=%0d z=%0d want v=1 id=0 y=44 c=1 z=0",
                     rsp_valid, rsp_id, rsp_y, rsp_carry, rsp_zero);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic exp_g;
        exp_g = 1'b1;  // req0 won last
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'd5;    req0_b = 8'd7;
        req1_valid = 1'b1; req1_op = 3'd7; req1_a = 8'hF0;   req1_b = 8'h0F;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if ({req1_ready, req0_ready} !== {exp_g, ~exp_g}) begin
                bad++;
                $display("FAIL rr_grant[%0d]: got r1r0=%b want %b", i,
                         {req1_ready, req0_ready}, {exp_g, ~exp_g});
            end
            tick();
            exp_g = ~exp_g;
        end
        idle_inputs();
        @(negedge clk);
        total++;
        if ({rsp_id, rsp_y, rsp_carry, rsp_zero} !== {1'b0, 8'hFE, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rr_last_rsp: got id=%0d y=%02h c=%0d z=%0d want id=0 y=fe c=1 z=0",
                     rsp_id, rsp_y, rsp_carry, rsp_zero);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'd1; req1_b = 8'd2;
        tick();
        req1_op = 3'd4; req1_a = 8'h50; req1_b = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({req1_ready, rsp_valid, rsp_id, rsp_y, rsp_carry, rsp_zero} !==
                {1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got rdy=%0d v=%0d id=%0d y=%02h c=%0d z=%0d want rdy=0 v=1 id=1 y=03 c=0 z=0",
                         i, req1_ready, rsp_valid, rsp_id, rsp_y, rsp_carry, rsp_zero);
            end
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got %0d want 1", req1_ready);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_y} !== {1'b1, 8'h55}) begin
            bad++;
            $display("FAIL bp_next_rsp: got v=%0d y=%02h want v=1 y=55", rsp_valid, rsp_y);
        end
        tick();
    endtask

    task automatic test_opcode_sweep();
        logic [W-1:0] exp_y [8];
        exp_y = '{8'hE1, 8'h69, 8'h24, 8'h99, 8'hBD, 8'hDB, 8'h42, 8'h66};
        rsp_ready = 1'b1;
        req1_a = 8'hA5; req1_b = 8'h3C;
        for (int i = 0; i <= 8; i++) begin
            req1_valid = (i < 8);
            req1_op    = 3'(i);
            @(negedge clk);
            if (i < 8) begin
                total++;
                if (req1_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL sweep_ready[%0d]: got %0d want 1", i, req1_ready);
                end
            end
            if (i > 0) begin
                total++;
                if ({rsp_valid, rsp_id, rsp_y, rsp_carry} !== {1'b1, 1'b1, exp_y[i-1], 1'b0}) begin
                    bad++;
                    $display("FAIL sweep_op%0d: got v=%0d id=%0d y=%02h c=%0d want v=1 id=1 y=%02h c=0",
                             i - 1, rsp_valid, rsp_id, rsp_y, rsp_carry, exp_y[i-1]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_idle_priority();
        rsp_ready = 1'b1;
        repeat (5) tick();
        req1_valid = 1'b1; req1_op = 3'd2; req1_a = 8'hFF; req1_b = 8'h0F;
        tick();
        idle_inputs();
        repeat (5) tick();
        req0_valid = 1'b1; req0_op = 3'd3; req0_a = 8'h12; req0_b = 8'h34;
        req1_valid = 1'b1; req1_op = 3'd6; req1_a = 8'h00; req1_b = 8'h00;
        @(negedge clk);
        total++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            bad++;
            $display("FAIL idle_contention: got r1r0=%b want 01", {req1_ready, req0_ready});
        end
        tick();
        @(negedge clk);
        total++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            bad++;
            $display("FAIL idle_second: got r1r0=%b want 10", {req1_ready, req0_ready});
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midop();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h10; req0_b = 8'h20;
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'h40; req1_b = 8'h01;
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({rsp_valid, rsp_y, req0_ready, req1_ready} !== 11'h0) begin
            bad++;
            $display("FAIL midop_reset: got v=%0d y=%02h r0=%0d r1=%0d want all 0",
                     rsp_valid, rsp_y, req0_ready, req1_ready);
        end
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            bad++;
            $display("FAIL midop_first_grant: got r1r0=%b want 01", {req1_ready, req0_ready});
        end
        tick();
        @(negedge clk);
        total++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            bad++;
            $display("FAIL midop_second_grant: got r1r0=%b want 10", {req1_ready, req0_ready});
        end
        tick();
        idle_inputs();
        repeat (2) tick();
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = '0; req1_b = '0;
        test_reset();
        test_single_add();
        test_fairness();
        test_backpressure();
        test_opcode_sweep();
        test_idle_priority();
        test_reset_midop();
        @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
